// File: rtl/entrada_clave_pkg.sv
// Shared ASCII codes and keypad-qualifier state encoding for the keypad scanner,
// PIN entry and UI blocks.
package entrada_clave_pkg;

    localparam logic [7:0] ASCII_CERO      = 8'h30;
    localparam logic [7:0] ASCII_NUEVE     = 8'h39;
    localparam logic [7:0] ASCII_ASTERISCO = 8'h2A;
    localparam logic [7:0] ASCII_NUMERAL   = 8'h23;
    localparam logic [7:0] ASCII_ERROR     = 8'h58;

    typedef enum logic [0:0] {
        ESPERA     = 1'b0,
        PRESIONADA = 1'b1
    } estado_calif_t;

    function automatic logic es_digito(input logic [7:0] c);
        return (c >= ASCII_CERO) && (c <= ASCII_NUEVE);
    endfunction

endpackage

// File: rtl/entrada_clave_calificador.sv
// Keypress qualifier: turns the scanner's repeating/gapping key-present flag into
// one accepted event per physical press, with a release timeout.
module calificador_tecla
    import entrada_clave_pkg::*;
#(
    parameter int CICLOS_LIBERACION = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_detected_i,
    input  logic [7:0] digito_i,
    output logic       tecla_valida_o,
    output logic [7:0] tecla_o
);

    localparam int CW = $clog2(CICLOS_LIBERACION + 1);
    localparam logic [CW-1:0] LIM_LIBERACION = CW'(CICLOS_LIBERACION - 1);

    estado_calif_t   estado_q, estado_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      tecla_q, tecla_d;
    logic            valida_q, valida_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q <= ESPERA;
            cnt_q    <= '0;
            tecla_q  <= '0;
            valida_q <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            tecla_q  <= tecla_d;
            valida_q <= valida_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        tecla_d  = tecla_q;
        valida_d = 1'b0;
        case (estado_q)
            ESPERA: begin
                // The scanner's error code never starts a press.
                if (key_detected_i && (digito_i != ASCII_ERROR)) begin
                    estado_d = PRESIONADA;
                    tecla_d  = digito_i;
                    valida_d = 1'b1;
                    cnt_d    = '0;
                end
            end
            PRESIONADA: begin
                if (key_detected_i) begin
                    cnt_d = '0;
                end else if (cnt_q == LIM_LIBERACION) begin
                    estado_d = ESPERA;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: estado_d = ESPERA;
        endcase
    end

    assign tecla_valida_o = valida_q;
    assign tecla_o        = tecla_q;

endmodule

// File: rtl/entrada_clave.sv
// PIN entry: digit buffer, clear/submit handling, compare and failure lockout.
// Build option ENTRADA_CLAVE_ECO_EN masks the displayed digits with '*'.
module entrada_clave
    import entrada_clave_pkg::*;
#(
    parameter int          CICLOS_LIBERACION = 50000,
    parameter int          LONG_CLAVE        = 4,
    parameter logic [63:0] CLAVE             = 64'h31323334,
    parameter int          MAX_FALLOS        = 3,
    parameter int          CICLOS_BLOQUEO    = 500000000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             key_detected,
    input  logic [7:0]                       digito,
    output logic                             tecla_valida,
    output logic [7:0]                       tecla,
    output logic [8*LONG_CLAVE-1:0]          digitos,
    output logic [$clog2(LONG_CLAVE+1)-1:0]  num_digitos,
    output logic                             clave_ok,
    output logic                             clave_error,
    output logic                             bloqueado
);

    localparam int BW = 8 * LONG_CLAVE;
    localparam int NW = $clog2(LONG_CLAVE + 1);
    localparam int FW = $clog2(MAX_FALLOS + 1);
    localparam int TW = $clog2(CICLOS_BLOQUEO + 1);
    localparam logic [NW-1:0] LONG_N      = NW'(LONG_CLAVE);
    localparam logic [FW-1:0] MAX_N       = FW'(MAX_FALLOS);
    localparam logic [FW-1:0] MAX_M1      = FW'(MAX_FALLOS - 1);
    localparam logic [TW-1:0] BLOQUEO_M1  = TW'(CICLOS_BLOQUEO - 1);
    localparam logic [BW-1:0] CLAVE_REF   = CLAVE[BW-1:0];

    logic          valida_w;
    logic [7:0]    tecla_w;

    logic [BW-1:0] buf_q, buf_d;
    logic [NW-1:0] num_q, num_d;
    logic [FW-1:0] fallos_q, fallos_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          bloq_q, bloq_d;
    logic          ok_q, ok_d;
    logic          err_q, err_d;

    calificador_tecla #(
        .CICLOS_LIBERACION(CICLOS_LIBERACION)
    ) u_calificador (
        .clk            (clk),
        .rst            (rst),
        .key_detected_i (key_detected),
        .digito_i       (digito),
        .tecla_valida_o (valida_w),
        .tecla_o        (tecla_w)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q    <= '0;
            num_q    <= '0;
            fallos_q <= '0;
            timer_q  <= '0;
            bloq_q   <= 1'b0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            buf_q    <= buf_d;
            num_q    <= num_d;
            fallos_q <= fallos_d;
            timer_q  <= timer_d;
            bloq_q   <= bloq_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        buf_d    = buf_q;
        num_d    = num_q;
        fallos_d = fallos_q;
        timer_d  = timer_q;
        bloq_d   = bloq_q;
        ok_d     = 1'b0;
        err_d    = 1'b0;
        if (bloq_q) begin
            // Keys are swallowed until the lockout timer expires.
            if (timer_q == '0) begin
                bloq_d   = 1'b0;
                fallos_d = '0;
            end else begin
                timer_d = timer_q - 1'b1;
            end
        end else if (valida_w) begin
            if (es_digito(tecla_w)) begin
                if (num_q < LONG_N) begin
                    // First digit lands in the MSB byte; later digits fill downward.
                    for (int i = 0; i < LONG_CLAVE; i++) begin
                        if (num_q == NW'(i)) begin
                            buf_d[8*(LONG_CLAVE-1-i) +: 8] = tecla_w;
                        end
                    end
                    num_d = num_q + 1'b1;
                end
            end else if (tecla_w == ASCII_ASTERISCO) begin
                buf_d = '0;
                num_d = '0;
            end else if (tecla_w == ASCII_NUMERAL) begin
                if ((num_q == LONG_N) && (buf_q == CLAVE_REF)) begin
                    ok_d     = 1'b1;
                    fallos_d = '0;
                end else begin
                    err_d = 1'b1;
                    if (fallos_q >= MAX_M1) begin
                        fallos_d = MAX_N;
                        bloq_d   = 1'b1;
                        timer_d  = BLOQUEO_M1;
                    end else begin
                        fallos_d = fallos_q + 1'b1;
                    end
                end
                buf_d = '0;
                num_d = '0;
            end
        end
    end

`ifdef ENTRADA_CLAVE_ECO_EN
    always_comb begin
        digitos = '0;
        for (int i = 0; i < LONG_CLAVE; i++) begin
            if (buf_q[8*i +: 8] != 8'h00) begin
                digitos[8*i +: 8] = ASCII_ASTERISCO;
            end
        end
    end
`else
    assign digitos = buf_q;
`endif

    assign tecla_valida = valida_w;
    assign tecla        = tecla_w;
    assign num_digitos  = num_q;
    assign clave_ok     = ok_q;
    assign clave_error  = err_q;
    assign bloqueado    = bloq_q;

endmodule

// File: tb/tb_entrada_clave.sv
// Scoreboard bench for entrada_clave: randomized key presses checked against a
// queue-based PIN-entry model.
module tb_entrada_clave;

    localparam int LIB   = 8;
    localparam int LC    = 4;
    localparam int MAXF  = 3;
    localparam int BLOQ  = 50;
    localparam logic [7:0] KX = 8'h58;

    localparam logic [1:0] K_KEY = 2'd0;
    localparam logic [1:0] K_OK  = 2'd1;
    localparam logic [1:0] K_ERR = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] v;
        logic       bl;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_detected = 1'b0;
    logic [7:0]  digito = 8'h00;
    logic        tecla_valida;
    logic [7:0]  tecla;
    logic [31:0] digitos;
    logic [2:0]  num_digitos;
    logic        clave_ok;
    logic        clave_error;
    logic        bloqueado;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    ev_t  exp_q[$];
    byte  m_buf[$];
    int   m_fails = 0;
    bit   m_locked = 0;
    int   m_lock_end = 0;

    entrada_clave #(
        .CICLOS_LIBERACION(LIB),
        .LONG_CLAVE(LC),
        .CLAVE(64'h31323334),
        .MAX_FALLOS(MAXF),
        .CICLOS_BLOQUEO(BLOQ)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_detected(key_detected),
        .digito(digito),
        .tecla_valida(tecla_valida),
        .tecla(tecla),
        .digitos(digitos),
        .num_digitos(num_digitos),
        .clave_ok(clave_ok),
        .clave_error(clave_error),
        .bloqueado(bloqueado)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic expect_ev(input logic [1:0] k, input logic [7:0] v, input logic bl);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event kind=%0d tecla=%0h at cycle %0d", k, v, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || (k == K_KEY && e.v != v) || (k != K_KEY && e.bl != bl)) begin
                failures++;
                $display("FAIL event actual kind=%0d val=%0h bl=%0b required kind=%0d val=%0h bl=%0b",
                         k, v, bl, e.kind, e.v, e.bl);
            end
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT reports something.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (tecla_valida) expect_ev(K_KEY, tecla, bloqueado);
                if (clave_ok)     expect_ev(K_OK, 8'h00, bloqueado);
                if (clave_error)  expect_ev(K_ERR, 8'h00, bloqueado);
                if (clave_ok && clave_error) chk("ok_err_exclusive", 1, 0);
            end
        end
    end

    function automatic logic [31:0] model_digitos();
        logic [31:0] r = '0;
        for (int i = 0; i < m_buf.size(); i++) begin
`ifdef ENTRADA_CLAVE_ECO_EN
            r[8*(LC-1-i) +: 8] = 8'h2A;
`else
            r[8*(LC-1-i) +: 8] = m_buf[i];
`endif
        end
        return r;
    endfunction

    function automatic bit model_match();
        string s = "1234";
        if (m_buf.size() != LC) return 0;
        for (int i = 0; i < LC; i++) if (m_buf[i] != s[i]) return 0;
        return 1;
    endfunction

    // Applied at the moment a press starts; its entry effect lands two edges later.
    task automatic model_key(input logic [7:0] c);
        ev_t e;
        if (c == KX) return;
        e.kind = K_KEY; e.v = c; e.bl = 1'b0;
        exp_q.push_back(e);
        if (m_locked) return;
        if (c >= 8'h30 && c <= 8'h39) begin
            if (m_buf.size() < LC) m_buf.push_back(c);
        end else if (c == 8'h2A) begin
            m_buf.delete();
        end else if (c == 8'h23) begin
            e.v = 8'h00;
            if (model_match()) begin
                e.kind = K_OK; e.bl = 1'b0; m_fails = 0;
            end else begin
                m_fails++;
                e.kind = K_ERR;
                e.bl = (m_fails >= MAXF);
                if (m_fails >= MAXF) begin
                    m_locked = 1;
                    m_lock_end = cyc + 2 + BLOQ;
                end
            end
            exp_q.push_back(e);
            m_buf.delete();
        end
    endtask

    task automatic model_reset();
        m_buf.delete();
        m_fails = 0;
        m_locked = 0;
    endtask

    // Keep presses and checks away from the lockout expiry edge.
    task automatic avoid_lock_edge(input int margin);
        if (m_locked && cyc >= m_lock_end - margin) begin
            while (cyc < m_lock_end + 2) @(negedge clk);
            m_locked = 0;
            m_fails = 0;
        end
    endtask

    task automatic press(input logic [7:0] c, input int hold);
        int zeros = 0;
        avoid_lock_edge(10);
        model_key(c);
        key_detected = 1'b1;
        digito = c;
        @(negedge clk);
        for (int i = 1; i < hold; i++) begin
            if (zeros < 3 && $urandom_range(0, 5) == 0) begin
                key_detected = 1'b0;
                zeros++;
            end else begin
                key_detected = 1'b1;
                zeros = 0;
                if (c != KX && $urandom_range(0, 4) == 0) digito = 8'($urandom_range(8'h20, 8'h5A));
                else digito = c;
            end
            @(negedge clk);
        end
        key_detected = 1'b0;
        digito = 8'h00;
        repeat (LIB + 4) @(negedge clk);
    endtask

    task automatic check_state(input string nm);
        avoid_lock_edge(3);
        chk({nm, "_digitos"}, digitos, model_digitos());
        chk({nm, "_num"}, num_digitos, m_buf.size());
        chk({nm, "_bloq"}, bloqueado, m_locked);
    endtask

    task automatic seq(input string s);
        for (int i = 0; i < s.len(); i++) press(s[i], $urandom_range(3, 20));
        check_state(s);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_valida"}, tecla_valida, 0);
        chk({nm, "_tecla"}, tecla, 0);
        chk({nm, "_digitos"}, digitos, 0);
        chk({nm, "_num"}, num_digitos, 0);
        chk({nm, "_ok"}, clave_ok, 0);
        chk({nm, "_err"}, clave_error, 0);
        chk({nm, "_bloq"}, bloqueado, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Long bouncing hold of '5': one event only.
        model_key(8'h35);
        for (int i = 0; i < 100; i++) begin
            key_detected = !((i % 20) >= 17);
            digito = 8'h35;
            @(negedge clk);
        end
        key_detected = 1'b0;
        repeat (LIB + 4) @(negedge clk);
        chk("hold_tecla", tecla, 8'h35);
        check_state("hold");

        seq("*");
        seq("1234#");
        seq("12#");
        seq("12345");
        chk("full_digitos", digitos, model_digitos());
        seq("#");
        seq("12*");
        seq("1234#");
        press(KX, 10);
        check_state("err_code");

        seq("9999#");
        seq("9999#");
        seq("9999#");
        chk("lock_bloq", bloqueado, 1);
        seq("1234#");
        repeat (BLOQ + 5) @(negedge clk);
        seq("1234#");

        // Reset while a key is held: the held key is accepted again afterwards.
        model_key(8'h37);
        key_detected = 1'b1;
        digito = 8'h37;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_all_zero("rst_press");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        model_key(8'h37);
        repeat (4) @(negedge clk);
        key_detected = 1'b0;
        repeat (LIB + 4) @(negedge clk);
        check_state("after_rst_press");

        // Reset in the middle of a lockout.
        seq("*");
        seq("0000#");
        seq("0000#");
        seq("0000#");
        chk("lock2_bloq", bloqueado, 1);
        #2 rst = 1'b1;
        #1 chk_all_zero("rst_lock");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        seq("1234#");

        for (int n = 0; n < 120; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0: seq("1234#");
                1: press(8'h23, $urandom_range(2, 25));
                2: press(8'h2A, $urandom_range(2, 25));
                3: press(8'(8'h41 + $urandom_range(0, 3)), $urandom_range(2, 25));
                4: press(KX, $urandom_range(2, 10));
                default: press(8'(8'h30 + $urandom_range(0, 9)), $urandom_range(2, 25));
            endcase
            check_state("rand");
        end

        repeat (20) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
